red_seq: RTL
============

RED_SEQ -- requirements
Module: red_seq

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a reduction; sampled only in IDLE or DONE.
REQ-005 flush  input  1  abort the operation in flight (pipeline squash).
REQ-006 rs  input  16  first operand; sampled only on an accepted start.
REQ-007 rt  input  16  second operand; sampled only on an accepted start.
REQ-008 busy  output  1  high while an operation is in flight (states AB, CD, SUM).
REQ-009 done  output  1  one-cycle pulse; rd is valid and new.
REQ-010 rd  output  16  registered reduction result; holds until the next completion.

Function
REQ-011 SHALL sequence one shared 10-bit adder over three compute cycles; it SHALL NOT instantiate parallel adders per operand pair.
REQ-012 FSM states SHALL be IDLE, AB, CD, SUM, DONE.
REQ-013 IDLE or DONE with start=1 at edge E0 SHALL latch rs and rt into operand registers and go to AB.
REQ-014 AB at E1 SHALL form sum_ab = {1'b0, rs[7:0]} + {1'b0, rs[15:8]} (9-bit unsigned, carry kept) and go to CD.
REQ-015 CD at E2 SHALL form sum_cd = {1'b0, rt[7:0]} + {1'b0, rt[15:8]} (9-bit unsigned) and go to SUM.
REQ-016 SUM at E3 SHALL form total = sum_ab + sum_cd (10-bit), write rd = {6{total[9]}, total[9:0]}, and go to DONE.
REQ-017 DONE SHALL last exactly one cycle with done=1, then go to IDLE, or to AB if start=1.
REQ-018 Latency: done SHALL be high in the cycle after E3, i.e. 4 cycles after the start edge.
REQ-019 Back-to-back throughput SHALL be one result per 4 cycles.
REQ-020 busy SHALL be high exactly in AB, CD and SUM; it SHALL be low in IDLE and DONE.
REQ-021 start in AB, CD or SUM SHALL be ignored: no latch and no queueing.
REQ-022 Operand registers SHALL NOT change while busy=1, regardless of rs and rt.
REQ-023 flush=1 in AB, CD or SUM SHALL force IDLE at the next edge, leave rd unchanged and produce no done.
REQ-024 flush=1 together with start in IDLE or DONE: flush SHALL win, the FSM SHALL go or stay IDLE, and no operands SHALL be latched.
REQ-025 flush in DONE SHALL NOT suppress the done pulse already visible in that cycle.
REQ-026 Overflow is not reported; wrap and sign extension SHALL follow REQ-016 exactly.

Reset
REQ-027 rst=1 SHALL force state IDLE, busy=0, done=0, rd=16'h0000 and all operand and partial-sum registers to 0.
REQ-028 rst SHALL take priority over start and flush.
REQ-029 rst asserted in any state, including mid-operation, SHALL abandon the operation with no done pulse.
REQ-030 The first start SHALL be accepted in the first cycle after rst deasserts.

Verification
REQ-031 rs=16'h0102, rt=16'h0304, start pulse -> busy for 3 cycles, then done=1 with rd=16'h000A.
REQ-032 rs=16'hFFFF, rt=16'hFFFF -> total=10'h3FC, rd=16'hFFFC at done; rs=16'h8080, rt=16'h0000 -> rd=16'h0100.
REQ-033 start held high continuously with new operands each DONE cycle -> done every 4th cycle, each rd matching its own operands; start pulses during busy are ignored.
REQ-034 flush asserted in CD -> IDLE next cycle, no done, rd retains the previous value (e.g. 16'h000A).
REQ-035 rst asserted in SUM -> next cycle shows busy=0, done=0, rd=16'h0000; a fresh start then completes normally.

Source files
------------

// File: rtl/red_seq_if.sv
// red_seq_if - request/result bundle for the red_seq byte-sum reducer.
//   start, flush : control from the requester
//   rs, rt       : 16-bit operands, sampled only when a start is accepted
//   busy         : high while a reduction is in flight
//   done         : one-cycle pulse when rd carries a fresh result
//   rd           : registered result, held until the next completion
interface red_seq_if;
  logic        start;
  logic        flush;
  logic [15:0] rs;
  logic [15:0] rt;
  logic        busy;
  logic        done;
  logic [15:0] rd;

  modport master (output start, flush, rs, rt, input busy, done, rd);
  modport slave  (input start, flush, rs, rt, output busy, done, rd);
endinterface

// File: rtl/red_seq.sv
// red_seq - adds the four bytes of rs and rt using a single shared 10-bit
// adder over three compute cycles and returns the sign-extended 10-bit total.
//   clk  : system clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : red_seq_if.slave (start, flush, rs, rt in; busy, done, rd out)
//
// state | meaning
// IDLE  | waiting for start
// AB    | adder sums the two bytes of rs
// CD    | adder sums the two bytes of rt
// SUM   | adder sums the partials, rd written
// DONE  | done pulse; start here chains directly into AB
module red_seq (
  input  logic      clk,
  input  logic      rst,
  red_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AB   = 3'd1,
    S_CD   = 3'd2,
    S_SUM  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] op_rs_q, op_rs_d;
  logic [15:0] op_rt_q, op_rt_d;
  logic [8:0]  sum_ab_q, sum_ab_d;
  logic [8:0]  sum_cd_q, sum_cd_d;
  logic [15:0] rd_q, rd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [9:0]  add_a;
  logic [9:0]  add_b;
  logic [9:0]  add_y;
  logic        accept;

  // The one adder; its operands are steered by the current state.
  always_comb begin
    add_a = '0;
    add_b = '0;
    case (state_q)
      S_AB: begin
        add_a = {2'b00, op_rs_q[7:0]};
        add_b = {2'b00, op_rs_q[15:8]};
      end
      S_CD: begin
        add_a = {2'b00, op_rt_q[7:0]};
        add_b = {2'b00, op_rt_q[15:8]};
      end
      S_SUM: begin
        add_a = {1'b0, sum_ab_q};
        add_b = {1'b0, sum_cd_q};
      end
      default: ;
    endcase
    add_y = add_a + add_b;
  end

  // flush beats start, so a flushed request never latches operands.
  assign accept = ((state_q == S_IDLE) || (state_q == S_DONE)) &&
                  bus.start && !bus.flush;

  always_comb begin
    state_d  = state_q;
    op_rs_d  = op_rs_q;
    op_rt_d  = op_rt_q;
    sum_ab_d = sum_ab_q;
    sum_cd_d = sum_cd_q;
    rd_d     = rd_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          op_rs_d = bus.rs;
          op_rt_d = bus.rt;
          state_d = S_AB;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_AB: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          sum_ab_d = add_y[8:0];
          state_d  = S_CD;
        end
      end
      S_CD: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          sum_cd_d = add_y[8:0];
          state_d  = S_SUM;
        end
      end
      S_SUM: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          // Bit 9 of the total is treated as a sign bit.
          rd_d    = {{6{add_y[9]}}, add_y};
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs are registered, so they are decoded from the next state.
    busy_d = (state_d == S_AB) || (state_d == S_CD) || (state_d == S_SUM);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_rs_q  <= '0;
      op_rt_q  <= '0;
      sum_ab_q <= '0;
      sum_cd_q <= '0;
      rd_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_rs_q  <= op_rs_d;
      op_rt_q  <= op_rt_d;
      sum_ab_q <= sum_ab_d;
      sum_cd_q <= sum_cd_d;
      rd_q     <= rd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.rd   = rd_q;

endmodule
